// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: word/count widths, slave FSM state encoding and
// the transmit-word alignment helper used when a frame starts.
package spi_slave_pkg;

  localparam int SPI_WORD_W  = 32;
  localparam int SPI_NBITS_W = 6;
  localparam int SPI_CNT_W   = 7;

  // Bit counter saturates one past a full word so overflow stays visible.
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_SAT  = 7'd33;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_FULL = 7'd32;

  typedef enum logic [1:0] {
    SPIS_IDLE   = 2'd0,
    SPIS_ACTIVE = 2'd1,
    SPIS_DONE   = 2'd2
  } spis_state_e;

  // Left-align a right-aligned word so its MSB (bit msb_idx) sits at bit 31.
  // The vacated low bits are filled with 1s so that MISO idles high once the
  // requested number of bits has been shifted out.
  function automatic logic [SPI_WORD_W-1:0] tx_align(
    input logic [SPI_WORD_W-1:0] data,
    input logic [4:0]            msb_idx
  );
    logic [4:0] sh;
    sh = 5'd31 - msb_idx;
    return (data << sh) | ~(32'hFFFF_FFFF << sh);
  endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Input synchronizer plus edge detector for one asynchronous SPI pin.
// A SYNC_STAGES-deep flop chain produces the synchronized level; a registered
// copy of that level yields one-cycle rise/fall strobes. RESET_VAL selects the
// level the chain assumes while nrst is low.
module spi_slave_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk_in,
  input  logic nrst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Shift the pin through the synchronizer chain and remember the last level.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = level & ~prev_r;
  assign fall  = ~level & prev_r;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 responder, MSB first, active-low CSN, 1-32 bit frames.
// All SPI pins are oversampled in the clk_in domain; nothing runs on SCK.
// Received words are presented with a one-cycle rx_valid pulse.
// Optional feature macro: SPI_SLAVE_MISO_TRISTATE_EN -- when defined, spi_miso
// floats (1'bz) while idle or in reset so the MISO line can be shared.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   nrst,
  input  logic [SPI_WORD_W-1:0]  tx_data,
  input  logic [SPI_NBITS_W-1:0] tx_nbits,
  output logic [SPI_WORD_W-1:0]  rx_data,
  output logic [SPI_NBITS_W-1:0] rx_nbits,
  output logic                   rx_overflow,
  output logic                   rx_valid,
  output logic                   busy,
  input  logic                   spi_csn,
  input  logic                   spi_sck,
  input  logic                   spi_mosi,
  output logic                   spi_miso
);

  // Synchronized levels and strobes
  logic csn_lvl_s, csn_rise_s, csn_fall_s;
  logic sck_lvl_s, sck_rise_s, sck_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  // FSM and control
  spis_state_e state_r, next_state_s;
  logic        start_s, tx_shift_en_s, rx_shift_en_s, finish_s;
  logic        pend_r;

  // Datapath
  logic [SPI_WORD_W-1:0]  tx_shift_r;
  logic [SPI_WORD_W-1:0]  rx_shift_r;
  logic [SPI_CNT_W-1:0]   cnt_r;
  logic                   miso_r;
  logic [SPI_WORD_W-1:0]  rx_data_r;
  logic [SPI_NBITS_W-1:0] rx_nbits_r;
  logic                   rx_overflow_r;
  logic                   rx_valid_r;
  logic                   busy_r;

  // CSN resets to "low" so a frame interrupted by reset raises no start
  // strobe; a new frame needs CSN seen high and then falling again.
  spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_csn (
    .clk_in (clk_in),
    .nrst   (nrst),
    .din    (spi_csn),
    .level  (csn_lvl_s),
    .rise   (csn_rise_s),
    .fall   (csn_fall_s)
  );

  spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
    .clk_in (clk_in),
    .nrst   (nrst),
    .din    (spi_sck),
    .level  (sck_lvl_s),
    .rise   (sck_rise_s),
    .fall   (sck_fall_s)
  );

  // MOSI goes through the same depth as SCK so data and clock stay aligned.
  spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_in (clk_in),
    .nrst   (nrst),
    .din    (spi_mosi),
    .level  (mosi_lvl_s),
    .rise   (mosi_rise_s),
    .fall   (mosi_fall_s)
  );

  assign unused_s = &{1'b0, tx_nbits[5], sck_lvl_s, mosi_rise_s, mosi_fall_s};

  // FSM state register.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_r <= SPIS_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle control strobes; csn_rise overrides SCK edges.
  always_comb begin
    next_state_s  = state_r;
    start_s       = 1'b0;
    tx_shift_en_s = 1'b0;
    rx_shift_en_s = 1'b0;
    finish_s      = 1'b0;
    case (state_r)
      SPIS_IDLE: begin
        if (csn_fall_s || (pend_r && !csn_lvl_s)) begin
          start_s      = 1'b1;
          next_state_s = SPIS_ACTIVE;
        end else begin
          next_state_s = SPIS_IDLE;
        end
      end
      SPIS_ACTIVE: begin
        if (csn_rise_s) begin
          next_state_s = SPIS_DONE;
        end else begin
          tx_shift_en_s = sck_fall_s;
          rx_shift_en_s = sck_rise_s;
          next_state_s  = SPIS_ACTIVE;
        end
      end
      SPIS_DONE: begin
        finish_s     = 1'b1;
        next_state_s = SPIS_IDLE;
      end
      default: begin
        next_state_s = SPIS_IDLE;
      end
    endcase
  end

  // Remember a CSN fall that arrived during DONE so IDLE can start next cycle.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      pend_r <= 1'b0;
    end else begin
      pend_r <= (state_r == SPIS_DONE) && csn_fall_s;
    end
  end

  // Transmit shifter and MISO launch register.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      tx_shift_r <= 32'h0000_0000;
      miso_r     <= 1'b1;
    end else if (start_s) begin
      tx_shift_r <= tx_align(tx_data, tx_nbits[4:0]);
      miso_r     <= 1'b1;
    end else if (tx_shift_en_s) begin
      miso_r     <= tx_shift_r[SPI_WORD_W-1];
      tx_shift_r <= {tx_shift_r[SPI_WORD_W-2:0], 1'b1};
    end else if (state_r == SPIS_IDLE) begin
      miso_r     <= 1'b1;
    end
  end

  // Receive shifter and saturating SCK-rise counter.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      rx_shift_r <= 32'h0000_0000;
      cnt_r      <= 7'd0;
    end else if (start_s) begin
      rx_shift_r <= 32'h0000_0000;
      cnt_r      <= 7'd0;
    end else if (rx_shift_en_s) begin
      rx_shift_r <= {rx_shift_r[SPI_WORD_W-2:0], mosi_lvl_s};
      if (cnt_r != SPI_CNT_SAT) begin
        cnt_r <= cnt_r + 7'd1;
      end
    end
  end

  // Publish the received word at frame end; empty frames leave outputs alone.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      rx_data_r     <= 32'h0000_0000;
      rx_nbits_r    <= 6'd0;
      rx_overflow_r <= 1'b0;
      rx_valid_r    <= 1'b0;
    end else if (finish_s && (cnt_r != 7'd0)) begin
      rx_data_r     <= rx_shift_r;
      rx_nbits_r    <= (cnt_r >= SPI_CNT_FULL) ? 6'd31 : (cnt_r[5:0] - 6'd1);
      rx_overflow_r <= (cnt_r == SPI_CNT_SAT);
      rx_valid_r    <= 1'b1;
    end else begin
      rx_valid_r    <= 1'b0;
    end
  end

  // Registered busy flag tracking the state the FSM is entering.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != SPIS_IDLE);
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_nbits    = rx_nbits_r;
  assign rx_overflow = rx_overflow_r;
  assign rx_valid    = rx_valid_r;
  assign busy        = busy_r;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign spi_miso = (!nrst || (state_r == SPIS_IDLE)) ? 1'bz : miso_r;
`else
  assign spi_miso = miso_r;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench acts as a mode-3 SPI master and
// checks received words, MISO data, overflow, empty frames and mid-frame reset.
module tb_spi_slave;

  logic        clk_in;
  logic        nrst;
  logic [31:0] tx_data;
  logic [5:0]  tx_nbits;
  logic [31:0] rx_data;
  logic [5:0]  rx_nbits;
  logic        rx_overflow;
  logic        rx_valid;
  logic        busy;
  logic        spi_csn;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  int tests;
  int fails;
  int valid_cnt;
  int v0;
  logic [63:0] m64;
  logic        mbit;

  localparam int HALF = 8;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk_in      (clk_in),
    .nrst        (nrst),
    .tx_data     (tx_data),
    .tx_nbits    (tx_nbits),
    .rx_data     (rx_data),
    .rx_nbits    (rx_nbits),
    .rx_overflow (rx_overflow),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .spi_csn     (spi_csn),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Count cycles with rx_valid high, sampled on the inactive edge.
  always @(negedge clk_in) begin
    if (rx_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SCK cycle: fall launches b, rise samples MISO (as the master would).
  task automatic sck_bit(input logic b, output logic m);
    spi_sck  = 1'b0;
    spi_mosi = b;
    wait_clks(HALF);
    m = spi_miso;
    spi_sck = 1'b1;
    wait_clks(HALF);
  endtask

  // Full frame of n bits, MSB first; returns MISO bits right-aligned.
  task automatic frame(input int n, input logic [63:0] w, output logic [63:0] m);
    logic b;
    m = 64'h0;
    spi_csn = 1'b0;
    wait_clks(HALF);
    for (int k = 0; k < n; k++) begin
      sck_bit(w[n-1-k], b);
      m = {m[62:0], b};
    end
    spi_csn = 1'b1;
    wait_clks(12);
  endtask

  initial begin
    tests = 0; fails = 0; valid_cnt = 0;
    nrst = 1'b0; spi_csn = 1'b1; spi_sck = 1'b1; spi_mosi = 1'b0;
    tx_data = 32'h0; tx_nbits = 6'd0;
    wait_clks(3);

    chk("rst_rx_data",  {32'h0, rx_data},  64'h0);
    chk("rst_rx_nbits", {58'h0, rx_nbits}, 64'h0);
    chk("rst_ovf",      {63'h0, rx_overflow}, 64'h0);
    chk("rst_valid",    {63'h0, rx_valid}, 64'h0);
    chk("rst_busy",     {63'h0, busy},     64'h0);
    chk("rst_miso",     {63'h0, spi_miso}, 64'h1);

    nrst = 1'b1;
    wait_clks(10);

    // 8-bit loop: master 0xA5, slave 0x3C
    tx_data = 32'h0000_003C; tx_nbits = 6'd7; v0 = valid_cnt;
    frame(8, 64'hA5, m64);
    chk("b8_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    chk("b8_rx_data",  {32'h0, rx_data},  64'hA5);
    chk("b8_rx_nbits", {58'h0, rx_nbits}, 64'd7);
    chk("b8_ovf",      {63'h0, rx_overflow}, 64'h0);
    chk("b8_miso",     m64, 64'h3C);
    chk("b8_idle_busy", {63'h0, busy}, 64'h0);

    // 32-bit frame
    tx_data = 32'h1234_5678; tx_nbits = 6'd31; v0 = valid_cnt;
    frame(32, 64'hDEAD_BEEF, m64);
    chk("b32_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    chk("b32_rx_data",  {32'h0, rx_data},  64'hDEAD_BEEF);
    chk("b32_rx_nbits", {58'h0, rx_nbits}, 64'd31);
    chk("b32_miso",     m64, 64'h1234_5678);

    // 1-bit frame
    tx_data = 32'h0; tx_nbits = 6'd0; v0 = valid_cnt;
    frame(1, 64'h1, m64);
    chk("b1_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    chk("b1_rx_data",  {32'h0, rx_data},  64'h1);
    chk("b1_rx_nbits", {58'h0, rx_nbits}, 64'd0);
    chk("b1_miso",     m64, 64'h0);

    // 36-bit overflow: bit index k carries k%2; 4-bit tx then MISO idles high
    tx_data = 32'h0000_000A; tx_nbits = 6'd3; v0 = valid_cnt;
    frame(36, 64'h5_5555_5555, m64);
    chk("ovf_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    chk("ovf_flag",     {63'h0, rx_overflow}, 64'h1);
    chk("ovf_rx_nbits", {58'h0, rx_nbits}, 64'd31);
    chk("ovf_rx_data",  {32'h0, rx_data},  64'h5555_5555);
    chk("ovf_miso",     m64, 64'hA_FFFF_FFFF);

    // CSN low 50 cycles, no SCK
    v0 = valid_cnt;
    spi_csn = 1'b0;
    wait_clks(50);
    chk("nosck_busy", {63'h0, busy}, 64'h1);
    spi_csn = 1'b1;
    wait_clks(12);
    chk("nosck_no_valid", 64'(valid_cnt - v0), 64'd0);
    chk("nosck_rx_data",  {32'h0, rx_data}, 64'h5555_5555);
    chk("nosck_ovf",      {63'h0, rx_overflow}, 64'h1);

    // Reset after 4 of 8 bits
    tx_data = 32'h0000_00FF; tx_nbits = 6'd7;
    spi_csn = 1'b0;
    wait_clks(HALF);
    for (int k = 0; k < 4; k++) sck_bit(k[0], mbit);
    chk("mid_busy", {63'h0, busy}, 64'h1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_rx_data",  {32'h0, rx_data},  64'h0);
    chk("mid_rst_rx_nbits", {58'h0, rx_nbits}, 64'h0);
    chk("mid_rst_ovf",      {63'h0, rx_overflow}, 64'h0);
    chk("mid_rst_busy",     {63'h0, busy},     64'h0);
    chk("mid_rst_miso",     {63'h0, spi_miso}, 64'h1);
    wait_clks(3);
    nrst = 1'b1;
    v0 = valid_cnt;
    for (int k = 0; k < 4; k++) sck_bit(k[0], mbit);
    chk("mid_rest_busy", {63'h0, busy}, 64'h0);
    spi_csn = 1'b1;
    wait_clks(12);
    chk("mid_no_valid", 64'(valid_cnt - v0), 64'd0);
    chk("mid_rx_data",  {32'h0, rx_data}, 64'h0);

    // Next full frame after the reset
    tx_data = 32'h0000_00C3; tx_nbits = 6'd7; v0 = valid_cnt;
    frame(8, 64'h5A, m64);
    chk("post_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    chk("post_rx_data",  {32'h0, rx_data},  64'h5A);
    chk("post_rx_nbits", {58'h0, rx_nbits}, 64'd7);
    chk("post_ovf",      {63'h0, rx_overflow}, 64'h0);
    chk("post_miso",     m64, 64'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
